// File: rtl/tetris_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_cmd_pkg
// Description : Command codes, input bit positions and the pulse encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_cmd_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_DOWN  = 3'd3,
    CMD_DROP  = 3'd4,
    CMD_ROT_L = 3'd5,
    CMD_ROT_R = 3'd6
  } cmd_t;

  localparam int BIT_LEFT  = 0;
  localparam int BIT_RIGHT = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_DROP  = 3;
  localparam int BIT_ROT_L = 4;
  localparam int BIT_ROT_R = 5;

  // Only one command survives a multi-bit pulse word; the rest are ignored.
  function automatic cmd_t encode_cmd(input logic [5:0] pulses);
    if (pulses[BIT_RIGHT])      encode_cmd = CMD_RIGHT;
    else if (pulses[BIT_LEFT])  encode_cmd = CMD_LEFT;
    else if (pulses[BIT_DOWN])  encode_cmd = CMD_DOWN;
    else if (pulses[BIT_DROP])  encode_cmd = CMD_DROP;
    else if (pulses[BIT_ROT_R]) encode_cmd = CMD_ROT_R;
    else if (pulses[BIT_ROT_L]) encode_cmd = CMD_ROT_L;
    else                        encode_cmd = CMD_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tetris_cmd_fifo
// Description : Synchronous command FIFO whose head entry is held in a register.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_cmd_fifo
  import tetris_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               push,
  input  logic [CMD_W-1:0]                   din,
  input  logic                               pop,
  output logic [CMD_W-1:0]                   dout,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_next;
  logic [LVL_W-1:0] r_level;
  logic [CMD_W-1:0] r_head;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);
  assign dout      = r_head;
  assign level     = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
    end
  end

  // Head register tracks the oldest entry so dout is zero whenever empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_level > LVL_W'(1)) r_head <= r_mem[w_rd_next];
      else if (w_push)         r_head <= din;
      else                     r_head <= '0;
    end else if (empty && w_push) begin
      r_head <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tetris_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tetris_cmd_scheduler
// Description : Arbitrates EPP, button and gravity commands into one FIFO.
//               Gravity source is built only when TETRIS_SCHED_GRAVITY_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GRAVITY_W  = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [5:0]                         epp_cmd,
  input  logic [5:0]                         btn_cmd,
  input  logic                               pause,
  input  logic                               flush,
  input  logic [GRAVITY_W-1:0]               gravity_period,
  output logic                               cmd_valid,
  output logic [CMD_W-1:0]                   cmd,
  input  logic                               cmd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic [7:0]                         drop_count
);

  logic [CMD_W-1:0] w_epp_new;
  logic [CMD_W-1:0] w_btn_new;
  logic [CMD_W-1:0] r_epp_pend;
  logic [CMD_W-1:0] r_btn_pend;
  logic             w_epp_req;
  logic             w_btn_req;
  logic             w_grav_req;
  logic             w_grant_epp;
  logic             w_grant_btn;
  logic             w_grant_grav;
  logic             w_epp_drop;
  logic             w_btn_drop;
  logic             w_grav_drop;
  logic [CMD_W-1:0] w_grav_data;
  logic             r_last_btn;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic             w_can_push;
  logic             w_push;
  logic [CMD_W-1:0] w_push_data;
  logic [8:0]       w_drop_sum;

  assign w_epp_new = encode_cmd(epp_cmd);
  assign w_btn_new = encode_cmd(btn_cmd);
  assign w_epp_req = (r_epp_pend != CMD_NONE);
  assign w_btn_req = (r_btn_pend != CMD_NONE);

  assign cmd_valid  = !w_fifo_empty;
  assign w_pop      = cmd_valid && cmd_ready && !pause;
  assign w_can_push = !w_fifo_full || w_pop;

`ifdef TETRIS_SCHED_GRAVITY_EN
  logic [GRAVITY_W-1:0] r_grav_cnt;
  logic [GRAVITY_W-1:0] w_grav_limit;
  logic [CMD_W-1:0]     r_grav_pend;
  logic                 w_grav_fire;

  // Periods below 2 are treated as 2; >= lets a shortened period apply at once.
  assign w_grav_limit = (gravity_period < GRAVITY_W'(2)) ? GRAVITY_W'(1)
                                                         : gravity_period - GRAVITY_W'(1);
  assign w_grav_fire  = !pause && (r_grav_cnt >= w_grav_limit);
  assign w_grav_req   = (r_grav_pend != CMD_NONE);
  assign w_grav_data  = r_grav_pend;
  assign w_grav_drop  = !flush && w_grav_fire && w_grav_req && !w_grant_grav;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_grav_cnt  <= '0;
      r_grav_pend <= CMD_NONE;
    end else begin
      if (!pause) r_grav_cnt <= w_grav_fire ? '0 : r_grav_cnt + GRAVITY_W'(1);
      if (w_grav_fire && (!w_grav_req || w_grant_grav)) r_grav_pend <= CMD_DOWN;
      else if (w_grant_grav)                            r_grav_pend <= CMD_NONE;
    end
  end
`else
  logic w_unused_period;
  assign w_unused_period = ^gravity_period;
  assign w_grav_req      = 1'b0;
  assign w_grav_data     = CMD_NONE;
  assign w_grav_drop     = 1'b0;
`endif

  // Gravity outranks the hosts; EPP/BTN alternate on ties.
  assign w_grant_grav = w_can_push && w_grav_req;
  assign w_grant_epp  = w_can_push && !w_grav_req && w_epp_req && (!w_btn_req || r_last_btn);
  assign w_grant_btn  = w_can_push && !w_grav_req && w_btn_req && (!w_epp_req || !r_last_btn);
  assign w_push       = w_grant_grav || w_grant_epp || w_grant_btn;
  assign w_push_data  = w_grant_grav ? w_grav_data :
                        w_grant_epp  ? r_epp_pend  : r_btn_pend;

  assign w_epp_drop = !flush && (w_epp_new != CMD_NONE) && w_epp_req && !w_grant_epp;
  assign w_btn_drop = !flush && (w_btn_new != CMD_NONE) && w_btn_req && !w_grant_btn;
  assign w_drop_sum = {1'b0, drop_count} + 9'(w_epp_drop) + 9'(w_btn_drop) + 9'(w_grav_drop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_epp_pend <= CMD_NONE;
      r_btn_pend <= CMD_NONE;
    end else begin
      if ((w_epp_new != CMD_NONE) && (!w_epp_req || w_grant_epp)) r_epp_pend <= w_epp_new;
      else if (w_grant_epp)                                       r_epp_pend <= CMD_NONE;
      if ((w_btn_new != CMD_NONE) && (!w_btn_req || w_grant_btn)) r_btn_pend <= w_btn_new;
      else if (w_grant_btn)                                       r_btn_pend <= CMD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_btn <= 1'b1;
      drop_count <= 8'd0;
    end else begin
      if (w_grant_epp)      r_last_btn <= 1'b0;
      else if (w_grant_btn) r_last_btn <= 1'b1;
      drop_count <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  tetris_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (w_push),
    .din   (w_push_data),
    .pop   (w_pop),
    .dout  (cmd),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (fifo_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_tetris_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetris_cmd_scheduler
// Description : Directed self-checking bench for tetris_cmd_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_cmd_scheduler;
  import tetris_cmd_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int GRAVITY_W  = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [5:0]           epp_cmd = '0;
  logic [5:0]           btn_cmd = '0;
  logic                 pause = 1'b0;
  logic                 flush = 1'b0;
  logic [GRAVITY_W-1:0] gravity_period = '1;
  logic                 cmd_valid;
  logic [CMD_W-1:0]     cmd;
  logic                 cmd_ready = 1'b0;
  logic [2:0]           fifo_level;
  logic [7:0]           drop_count;

  int tests = 0;
  int fails = 0;

  tetris_cmd_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GRAVITY_W  (GRAVITY_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .epp_cmd        (epp_cmd),
    .btn_cmd        (btn_cmd),
    .pause          (pause),
    .flush          (flush),
    .gravity_period (gravity_period),
    .cmd_valid      (cmd_valid),
    .cmd            (cmd),
    .cmd_ready      (cmd_ready),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; epp_cmd = '0; btn_cmd = '0; pause = 1'b0; flush = 1'b0;
    cmd_ready = 1'b0; gravity_period = '1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0d expected 0", cmd_valid); end
    tests++; if (cmd !== 3'd0) begin fails++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
  endtask

  task automatic test_single_cmd();
    cmd_ready = 1'b1;
    epp_cmd = 6'b000010; tick(); epp_cmd = '0;
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %0d expected 0", cmd_valid); end
    tick();
    tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin fails++; $display("FAIL single_cmd: got valid=%0d cmd=%0d expected valid=1 cmd=2", cmd_valid, cmd); end
    tick();
    tests++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0 || cmd !== 3'd0) begin fails++; $display("FAIL single_drain: got level=%0d valid=%0d cmd=%0d expected 0/0/0", fifo_level, cmd_valid, cmd); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      epp_cmd = 6'b000001; tick(); epp_cmd = '0; tick();
    end
    tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL bp_level: got %0d expected 4", fifo_level); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL bp_drop: got %0d expected 1", drop_count); end
    tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin fails++; $display("FAIL bp_head: got valid=%0d cmd=%0d expected valid=1 cmd=1", cmd_valid, cmd); end
    cmd_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) n++;
      tick();
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL bp_drain_count: got %0d expected 5", n); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL bp_drain_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_flush();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      epp_cmd = 6'b000001; tick(); epp_cmd = '0; tick();
    end
    tests++; if (fifo_level !== 3'd3) begin fails++; $display("FAIL flush_fill: got %0d expected 3", fifo_level); end
    flush = 1'b1; btn_cmd = 6'b000100; tick(); flush = 1'b0; btn_cmd = '0;
    tests++; if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin fails++; $display("FAIL flush_clear: got level=%0d valid=%0d expected 0/0", fifo_level, cmd_valid); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL flush_drop: got %0d expected 1", drop_count); end
    tick(); tick();
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL flush_pulse_discard: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_multi_bit();
    cmd_ready = 1'b1;
    epp_cmd = 6'b111111; tick(); epp_cmd = '0; tick();
    tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin fails++; $display("FAIL multi_cmd: got valid=%0d cmd=%0d expected valid=1 cmd=2", cmd_valid, cmd); end
    tick();
    tests++; if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin fails++; $display("FAIL multi_single: got valid=%0d level=%0d expected 0/0", cmd_valid, fifo_level); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL multi_drop: got %0d expected 1", drop_count); end
  endtask

  task automatic test_pause();
    cmd_ready = 1'b1; pause = 1'b1;
    btn_cmd = 6'b010000; tick(); btn_cmd = '0; tick();
    tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin fails++; $display("FAIL pause_enq: got valid=%0d cmd=%0d expected valid=1 cmd=5", cmd_valid, cmd); end
    tick(); tick(); tick();
    tests++; if (cmd_valid !== 1'b1 || fifo_level !== 3'd1) begin fails++; $display("FAIL pause_hold: got valid=%0d level=%0d expected 1/1", cmd_valid, fifo_level); end
    pause = 1'b0; tick();
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL pause_release: got %0d expected 0", cmd_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    cmd_ready = 1'b1;
    epp_cmd = 6'b000001; btn_cmd = 6'b100000; tick(); epp_cmd = '0; btn_cmd = '0; tick();
    tests++; if (cmd !== 3'd1) begin fails++; $display("FAIL rr_first_a: got %0d expected 1", cmd); end
    tick();
    tests++; if (cmd !== 3'd6) begin fails++; $display("FAIL rr_first_b: got %0d expected 6", cmd); end
    tick();
    tests++; if (cmd_valid !== 1'b0) begin fails++; $display("FAIL rr_idle: got %0d expected 0", cmd_valid); end
    // a lone EPP grant leaves EPP as last-granted, so BTN wins the next tie
    epp_cmd = 6'b000010; tick(); epp_cmd = '0; tick(); tick();
    epp_cmd = 6'b000001; btn_cmd = 6'b100000; tick(); epp_cmd = '0; btn_cmd = '0; tick();
    tests++; if (cmd !== 3'd6) begin fails++; $display("FAIL rr_second_a: got %0d expected 6", cmd); end
    tick();
    tests++; if (cmd !== 3'd1) begin fails++; $display("FAIL rr_second_b: got %0d expected 1", cmd); end
  endtask

`ifdef TETRIS_SCHED_GRAVITY_EN
  task automatic test_gravity();
    int n, first, wait_n;
    bit seen;
    do_reset();
    gravity_period = 24'd10; cmd_ready = 1'b1;
    n = 0; first = 0;
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (cmd_valid) begin
        n++;
        if (first == 0) first = t;
        tests++; if (cmd !== 3'd3) begin fails++; $display("FAIL grav_code: got %0d expected 3", cmd); end
      end
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL grav_count: got %0d expected 3", n); end
    tests++; if (first !== 11) begin fails++; $display("FAIL grav_first: got %0d expected 11", first); end
    pause = 1'b1; seen = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL grav_pause: got %0d expected 0", seen); end
    pause = 1'b0; wait_n = 0;
    while (!cmd_valid && wait_n < 40) begin
      tick(); wait_n++;
    end
    tests++; if (wait_n !== 9) begin fails++; $display("FAIL grav_resume: got %0d expected 9", wait_n); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_cmd();
    test_backpressure();
    test_flush();
    test_multi_bit();
    test_pause();
    test_round_robin();
`ifdef TETRIS_SCHED_GRAVITY_EN
    test_gravity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
